// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locked sharing of one UART transmit byte path among NUM_SRC FIFO sources
module uart_tx_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST = 16,
   parameter int TERM_EN = 1,
   parameter logic [DATA_WIDTH-1:0] TERM_CHAR = 8'h0A
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            src_empty,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_read_en,
   output logic                          out_empty,
   output logic [DATA_WIDTH-1:0]         out_data,
   input  logic                          out_read_en,
   output logic [NUM_SRC-1:0]            grant,
   output logic                          busy
);
   localparam int IW = $clog2(NUM_SRC);
   localparam logic [IW:0] NS = (IW+1)'(NUM_SRC);
   localparam logic [IW-1:0] LAST = IW'(NUM_SRC - 1);
   localparam logic [7:0] MB = 8'(MAX_BURST);
   localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);
   typedef enum logic [1:0] {IDLE, REQ, CAPTURE, HOLD} state_t;
   state_t state;
   logic [IW-1:0] rr_ptr, sel, pick;
   logic [IW:0] j;
   logic [7:0] burst_cnt;
   logic valid, found, release_now;
   assign src_read_en = (state == REQ) ? grant : '0;
   assign out_empty = ~valid;
   assign busy = state != IDLE;
   assign release_now = (burst_cnt == MB) || (TERM_EN != 0 && out_data == TERM_CHAR) || src_empty[sel];
   // first non-empty source at or after rr_ptr, wrapping; lowest offset wins
   always_comb begin
      found = 1'b0;
      pick = '0;
      j = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         j = {1'b0, rr_ptr} + (IW+1)'(k);
         j = (j >= NS) ? j - NS : j;
         if (!src_empty[j[IW-1:0]]) begin
            found = 1'b1;
            pick = j[IW-1:0];
         end
      end
   end
   // grant/request/capture/hold sequencing with the burst-lock release rules
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         rr_ptr <= '0;
         sel <= '0;
         burst_cnt <= '0;
         valid <= 1'b0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               grant <= ONE << pick;
               sel <= pick;
               burst_cnt <= '0;
               state <= REQ;
            end
            REQ: state <= CAPTURE;
            CAPTURE: begin
               out_data <= src_data[sel*DATA_WIDTH +: DATA_WIDTH];
               valid <= 1'b1;
               burst_cnt <= burst_cnt + 8'd1;
               state <= HOLD;
            end
            HOLD: if (out_read_en) begin
               valid <= 1'b0;
               if (release_now) begin
                  grant <= '0;
                  rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
                  state <= IDLE;
               end else begin
                  state <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a queue-level arbitration model
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam logic [7:0] TC = 8'h0A;
   typedef struct {
      int src;
      logic [7:0] b;
      bit first;
   } item_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] src_empty = '1;
   logic [N-1:0] src_read_en, grant;
   logic [N*DW-1:0] src_data;
   logic out_empty, busy;
   logic out_read_en = 1'b0;
   logic [DW-1:0] out_data;
   logic [DW-1:0] sd [N];
   logic [DW-1:0] fq [N][$];
   logic [DW-1:0] pend [N][$];
   logic [DW-1:0] mq [N][$];
   item_t exp_q[$];
   int mrr = 0;
   int total = 0;
   int bad = 0;
   int gap = 0;
   bit gap_on = 1'b0;
   logic [7:0] last = '0;
   // second instance: no terminator release
   logic [N-1:0] nt_empty, nt_rd, nt_grant;
   logic nt_oe, nt_busy, nt_ord;
   logic [DW-1:0] nt_od;
   logic [DW-1:0] nt_d1, nt_d2;
   logic [2:0] p1 = '0;
   logic p2 = 1'b0;
   logic nt_go = 1'b0;
   logic [7:0] nt_rom [4] = '{8'h68, 8'h69, 8'h0A, 8'h78};
   logic [7:0] nt_exp [5] = '{8'h68, 8'h69, 8'h0A, 8'h78, 8'h7A};
   logic [7:0] nt_got[$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .TERM_EN(1), .TERM_CHAR(TC)) dut (
      .clk(clk), .rst(rst), .src_empty(src_empty), .src_data(src_data), .src_read_en(src_read_en),
      .out_empty(out_empty), .out_data(out_data), .out_read_en(out_read_en), .grant(grant), .busy(busy));

   uart_tx_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(16), .TERM_EN(0), .TERM_CHAR(TC)) u_nt (
      .clk(clk), .rst(rst), .src_empty(nt_empty), .src_data({8'h00, nt_d2, nt_d1, 8'h00}), .src_read_en(nt_rd),
      .out_empty(nt_oe), .out_data(nt_od), .out_read_en(nt_ord), .grant(nt_grant), .busy(nt_busy));

   for (genvar g = 0; g < N; g++) assign src_data[g*DW +: DW] = sd[g];

   assign nt_empty = {1'b1, !(nt_go && !p2), !(nt_go && p1 < 3'd4), 1'b1};
   assign nt_ord = !nt_oe;

   // source FIFOs: pop on read strobe (data next cycle), then take pending pushes
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (src_read_en[i] && fq[i].size() > 0) sd[i] <= fq[i].pop_front();
         while (pend[i].size() > 0) fq[i].push_back(pend[i].pop_front());
         src_empty[i] <= (fq[i].size() == 0);
      end
   end

   // sources of the no-terminator instance
   always @(posedge clk) begin
      if (nt_rd[1] && p1 < 3'd4) begin
         nt_d1 <= nt_rom[p1[1:0]];
         p1 <= p1 + 3'd1;
      end
      if (nt_rd[2] && !p2) begin
         nt_d2 <= 8'h7A;
         p2 <= 1'b1;
      end
   end

   always @(negedge clk) if (!nt_oe) nt_got.push_back(nt_od);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic load(input int s, input logic [7:0] b);
      pend[s].push_back(b);
      mq[s].push_back(b);
   endtask

   // expected output order: round robin from mrr, each grant drains up to MB bytes or through a terminator
   task automatic build();
      int w;
      int n;
      logic [7:0] b;
      while (1) begin
         w = -1;
         for (int k = 0; k < N; k++) if (w < 0 && mq[(mrr + k) % N].size() > 0) w = (mrr + k) % N;
         if (w < 0) break;
         n = 0;
         do begin
            b = mq[w].pop_front();
            exp_q.push_back('{src: w, b: b, first: (n == 0)});
            n++;
         end while (mq[w].size() > 0 && n < MB && b != TC);
         mrr = (w + 1) % N;
      end
   endtask

   task automatic step(input int pct);
      item_t e;
      logic rd;
      @(negedge clk);
      rd = int'($urandom_range(0, 99)) < pct;
      if (!out_empty) begin
         if (gap_on && exp_q.size() > 0) chk("gap", 32'(gap), exp_q[0].first ? 32'd3 : 32'd2);
         gap_on = 1'b0;
         if (rd) begin
            if (exp_q.size() == 0) chk("extra_byte", 32'(out_empty), 32'd1);
            else begin
               e = exp_q.pop_front();
               chk("data", 32'(out_data), 32'(e.b));
               chk("grant", 32'(grant), 32'd1 << e.src);
               last = e.b;
               gap = 0;
               gap_on = 1'b1;
            end
         end
      end else if (gap_on) begin
         gap++;
         if (gap <= 2) chk("hold", 32'(out_data), 32'(last));
      end
      out_read_en = rd;
   endtask

   task automatic drain(input int pct);
      int n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         step(pct);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      gap_on = 1'b0;
      repeat (6) step(pct);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_empty", 32'(out_empty), 32'd1);
      chk("idle_grant", 32'(grant), 32'd0);
   endtask

   initial begin
      int n;
      int cnt;
      repeat (2) @(negedge clk);
      chk("rst_empty", 32'(out_empty), 32'd1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rden", 32'(src_read_en), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      // single source, always-ready consumer
      load(2, 8'h41); load(2, 8'h42); load(2, 8'h43);
      build();
      drain(100);
      // round robin continues after source 2
      load(0, 8'h10); load(1, 8'h11); load(3, 8'h13);
      build();
      drain(70);
      load(0, 8'h20); load(1, 8'h21);
      build();
      drain(70);
      // burst limit
      for (int i = 0; i < 10; i++) load(0, 8'(8'hA0 + i));
      load(3, 8'h33);
      build();
      drain(80);
      // terminator release
      load(1, 8'h68); load(1, 8'h69); load(1, 8'h0A); load(1, 8'h78);
      load(2, 8'h7A);
      build();
      drain(90);
      // consumer stall
      load(0, 8'h3C);
      build();
      n = 0;
      while (out_empty && n < 20) begin
         step(0);
         n++;
      end
      repeat (50) begin
         step(0);
         chk("stall_data", 32'(out_data), 32'h3C);
         chk("stall_rden", 32'(src_read_en), 32'd0);
         chk("stall_empty", 32'(out_empty), 32'd0);
      end
      drain(100);
      // randomized traffic
      repeat (25) begin
         for (int i = 0; i < N; i++) begin
            cnt = $urandom_range(0, 7);
            for (int c = 0; c < cnt; c++) load(i, ($urandom_range(0, 3) == 0) ? TC : 8'($urandom_range(0, 255)));
         end
         build();
         drain($urandom_range(30, 100));
      end
      // asynchronous reset with a byte held
      load(2, 8'h55);
      build();
      n = 0;
      while (out_empty && n < 20) begin
         step(0);
         n++;
      end
      chk("pre_rst_data", 32'(out_data), 32'h55);
      #2 rst = 1'b1;
      #1;
      chk("arst_rden", 32'(src_read_en), 32'd0);
      chk("arst_empty", 32'(out_empty), 32'd1);
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      gap_on = 1'b0;
      mrr = 0;
      @(negedge clk);
      rst = 1'b0;
      load(3, 8'h93); load(1, 8'h91);
      build();
      drain(100);
      // no-terminator instance keeps the grant through 0x0A
      nt_go = 1'b1;
      n = 0;
      while (nt_got.size() < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("nt_count", 32'(nt_got.size()), 32'd5);
      for (int i = 0; i < 5; i++) if (i < nt_got.size()) chk("nt_byte", 32'(nt_got[i]), 32'(nt_exp[i]));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
